// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO ahead of the uart that paces each byte as a fixed dte strobe plus frame hold.
// Optional sticky drop flag (overflow/overflow_clr) is built when UART_TX_QUEUE_OVERFLOW_EN is defined.
module uart_tx_queue #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AW          = 4,
  parameter int unsigned STROBE_CLKS = 20000,
  parameter int unsigned FRAME_CLKS  = 110000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  wr_data,
  input  logic        wr_en,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count,
  output logic [7:0]  data_transmit,
  output logic        dte,
  output logic        busy
`ifdef UART_TX_QUEUE_OVERFLOW_EN
  ,
  input  logic        overflow_clr,
  output logic        overflow
`endif
);

  localparam int unsigned TW = $clog2(FRAME_CLKS + 1);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t        r_state;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic [7:0]    r_data;
  logic          r_dte;
  logic          r_busy;
  logic [TW-1:0] r_timer;

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_nxt;

  // A pop only ever happens from IDLE, so the FSM alone decides when the queue drains.
  assign w_push = wr_en && !r_full;
  assign w_pop  = (r_state == IDLE) && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_data   <= 8'h00;
      r_dte    <= 1'b0;
      r_busy   <= 1'b0;
      r_timer  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);

      // Timer runs from the dte rise; strobe ends at STROBE_CLKS, frame at FRAME_CLKS.
      case (r_state)
        IDLE: begin
          if (!r_empty) begin
            r_data   <= r_mem[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + AW'(1);
            r_dte    <= 1'b1;
            r_busy   <= 1'b1;
            r_timer  <= TW'(1);
            r_state  <= STROBE;
          end
        end
        STROBE: begin
          r_timer <= r_timer + TW'(1);
          if (r_timer == TW'(STROBE_CLKS)) begin
            r_dte   <= 1'b0;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (r_timer == TW'(FRAME_CLKS)) begin
            r_timer <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: begin
          r_dte   <= 1'b0;
          r_busy  <= 1'b0;
          r_timer <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign full          = r_full;
  assign empty         = r_empty;
  assign count         = r_count;
  assign data_transmit = r_data;
  assign dte           = r_dte;
  assign busy          = r_busy;

`ifdef UART_TX_QUEUE_OVERFLOW_EN
  logic r_overflow;

  // Set has priority over clear so a drop coinciding with a clear is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (wr_en && r_full) begin
      r_overflow <= 1'b1;
    end else if (overflow_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign overflow = r_overflow;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed plus random stimulus against a queue/timing reference model,
// with a byte scoreboard popped on every dte rise.
module tb_uart_tx_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int S     = 8;
  localparam int F     = 40;

  logic        clk          = 1'b0;
  logic        reset        = 1'b1;
  logic        wr_en        = 1'b0;
  logic [7:0]  wr_data      = 8'h00;
  logic        overflow_clr = 1'b0;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic [7:0]  data_transmit;
  logic        dte;
  logic        busy;
`ifdef UART_TX_QUEUE_OVERFLOW_EN
  logic        overflow;
`endif

  uart_tx_queue #(
    .DEPTH(DEPTH), .AW(AW), .STROBE_CLKS(S), .FRAME_CLKS(F)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_data(wr_data),
    .wr_en(wr_en),
    .full(full),
    .empty(empty),
    .count(count),
    .data_transmit(data_transmit),
    .dte(dte),
    .busy(busy)
`ifdef UART_TX_QUEUE_OVERFLOW_EN
    ,
    .overflow_clr(overflow_clr),
    .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a byte queue plus the edge index of the last dte rise.
  logic [7:0] m_q[$];
  logic [7:0] sb_q[$];
  int         m_edge     = 0;
  int         m_last_pop = -1000;
  logic [7:0] m_data     = 8'h00;
  logic       m_ovf      = 1'b0;
  logic       m_started  = 1'b0;
  logic       prev_dte   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, m_edge);
    end
  endtask

  always @(posedge clk) begin
    m_edge++;
    if (reset) begin
      m_q.delete();
      sb_q.delete();
      m_last_pop = -1000;
      m_data     = 8'h00;
      m_ovf      = 1'b0;
    end else begin
      bit do_pop;
      bit do_push;
      do_pop  = (m_q.size() > 0) && (m_edge >= m_last_pop + F + 1);
      do_push = wr_en && (m_q.size() < DEPTH);
      if (wr_en && m_q.size() == DEPTH) m_ovf = 1'b1;
      else if (overflow_clr)            m_ovf = 1'b0;
      if (do_pop) begin
        m_data     = m_q.pop_front();
        m_last_pop = m_edge;
      end
      if (do_push) begin
        m_q.push_back(wr_data);
        sb_q.push_back(wr_data);
      end
    end
    m_started = 1'b1;
  end

  // Per-cycle status checker against the model.
  always @(negedge clk) begin
    if (m_started) begin
      int age;
      age = m_edge - m_last_pop;
      chk("count", 32'(count), 32'(m_q.size()));
      chk("full", 32'(full), 32'(m_q.size() == DEPTH));
      chk("empty", 32'(empty), 32'(m_q.size() == 0));
      chk("dte", 32'(dte), 32'(age < S));
      chk("busy", 32'(busy), 32'(age < F));
      chk("data_transmit", 32'(data_transmit), 32'(m_data));
`ifdef UART_TX_QUEUE_OVERFLOW_EN
      chk("overflow", 32'(overflow), 32'(m_ovf));
`endif
    end
  end

  // Scoreboard monitor: every dte rise must present the oldest accepted byte.
  always @(negedge clk) begin
    if (m_started && dte && !prev_dte) begin
      chk("sb_has_byte", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        logic [7:0] e;
        e = sb_q.pop_front();
        chk("sb_byte", 32'(data_transmit), 32'(e));
      end
    end
    prev_dte = dte;
  end

  task automatic cyc(input logic we, input logic [7:0] d, input logic clr, input logic rst);
    wr_en        = we;
    wr_data      = d;
    overflow_clr = clr;
    reset        = rst;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    @(negedge clk);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    idle(20);

    // Single byte latency and frame timing.
    cyc(1'b1, 8'h41, 1'b0, 1'b0);
    idle(50);

    // Back-to-back fill, then a dropped write while full, then clear the flag.
    for (int i = 1; i <= 5; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    chk("full_after_fill", 32'(full), 32'd1);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("count_after_drop", 32'(count), 32'd4);
    idle(10);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    idle(230);

    // Reset during STROBE with two bytes waiting.
    cyc(1'b1, 8'hA1, 1'b0, 1'b0);
    cyc(1'b1, 8'hA2, 1'b0, 1'b0);
    cyc(1'b1, 8'hA3, 1'b0, 1'b0);
    idle(2);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("reset_midframe_dte", 32'(dte), 32'd0);
    chk("reset_midframe_count", 32'(count), 32'd0);
    idle(60);

    // Push on the same edge as a pop with two entries held.
    cyc(1'b1, 8'hB1, 1'b0, 1'b0);
    cyc(1'b1, 8'hB2, 1'b0, 1'b0);
    cyc(1'b1, 8'hB3, 1'b0, 1'b0);
    n = 0;
    while (!((m_q.size() > 0) && (m_edge + 1 >= m_last_pop + F + 1)) && n < 100) begin
      idle(1);
      n++;
    end
    chk("pop_edge_reached", 32'(n < 100), 32'd1);
    cyc(1'b1, 8'hB4, 1'b0, 1'b0);
    chk("push_pop_count", 32'(count), 32'd2);
    idle(140);

    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 19) == 0), 8'($urandom),
          1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1499) == 0));
    end
    idle(250);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("model_drained", 32'(m_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
